gcd_stein_unit: RTL and testbench

- Parametrised successor to the two-operand GCD engine: computes gcd(a,b) on unsigned DATA_WIDTH operands using the binary (Stein) algorithm.
- Valid/ready handshakes on input and output replace the enable-driven interface.
- Reports the iteration count and a zero-result flag; a single FSM and datapath sit in one module.
- Sits between the operand source and the result consumer in the arithmetic cluster.

---
 rtl/gcd_stein_unit.sv | 134 +++++++++++++
 tb/tb_gcd_stein_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine with valid/ready handshakes on operands and result.
// Reports the number of compute cycles spent and flags the all-zero case.
module gcd_stein_unit #(
  parameter int DATA_WIDTH = 16,
  localparam int CNT_WIDTH = $clog2(4 * DATA_WIDTH + 4)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic                  zero_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  // k counts shared factors of two; it never reaches DATA_WIDTH for nonzero operands.
  localparam int K_WIDTH = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STRIP,
    REDUCE,
    DONE
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] a, a_n;
  logic [DATA_WIDTH-1:0] b, b_n;
  logic [K_WIDTH-1:0]    k, k_n;
  logic [CNT_WIDTH-1:0]  count, count_n;
  logic [DATA_WIDTH-1:0] gcd_n;
  logic                  zero_n;
  logic [CNT_WIDTH-1:0]  cycles_n;

  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    k_n      = k;
    count_n  = count;
    gcd_n    = gcd_o;
    zero_n   = zero_o;
    cycles_n = cycles_o;
    case (state)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          a_n     = operand_a_i;
          b_n     = operand_b_i;
          k_n     = '0;
          count_n = '0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        count_n = count + CNT_WIDTH'(1);
        if (a == '0 || b == '0) begin
          gcd_n    = a | b;
          zero_n   = (a == '0) && (b == '0);
          cycles_n = count_n;
          state_n  = DONE;
        end else begin
          state_n = STRIP;
        end
      end
      STRIP: begin
        count_n = count + CNT_WIDTH'(1);
        if (!a[0] && !b[0]) begin
          a_n = a >> 1;
          b_n = b >> 1;
          k_n = k + K_WIDTH'(1);
        end else begin
          state_n = REDUCE;
        end
      end
      REDUCE: begin
        // Both operands are nonzero here, so differences of odd values stay in range.
        count_n = count + CNT_WIDTH'(1);
        if (a == b) begin
          gcd_n    = a << k;
          zero_n   = 1'b0;
          cycles_n = count_n;
          state_n  = DONE;
        end else if (!a[0]) begin
          a_n = a >> 1;
        end else if (!b[0]) begin
          b_n = b >> 1;
        end else if (a > b) begin
          a_n = (a - b) >> 1;
        end else begin
          b_n = (b - a) >> 1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags decode the next state so they line up with the state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      k           <= '0;
      count       <= '0;
      gcd_o       <= '0;
      zero_o      <= 1'b0;
      cycles_o    <= '0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      b           <= b_n;
      k           <= k_n;
      count       <= count_n;
      gcd_o       <= gcd_n;
      zero_o      <= zero_n;
      cycles_o    <= cycles_n;
      in_ready_o  <= (state_n == IDLE);
      out_valid_o <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Testbench for gcd_stein_unit: directed vector table, handshake/reset corner cases,
// and a randomized run against a Euclid gcd plus a Stein step-count reference.
module tb_gcd_stein_unit;

  localparam int DW  = 16;
  localparam int CW  = $clog2(4 * DW + 4);
  localparam int DW8 = 8;
  localparam int CW8 = $clog2(4 * DW8 + 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, zero;
  logic [DW-1:0] a_in, b_in, gcd;
  logic [CW-1:0] cycles;

  logic           in_valid8, in_ready8, out_valid8, zero8;
  logic [DW8-1:0] a_in8, b_in8, gcd8;
  logic [CW8-1:0] cycles8;

  int checks = 0;
  int errors = 0;

  gcd_stein_unit #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .operand_a_i(a_in), .operand_b_i(b_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .gcd_o(gcd), .zero_o(zero), .cycles_o(cycles)
  );

  gcd_stein_unit #(.DATA_WIDTH(DW8)) dut8 (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .operand_a_i(a_in8), .operand_b_i(b_in8),
    .out_valid_o(out_valid8), .out_ready_i(1'b1),
    .gcd_o(gcd8), .zero_o(zero8), .cycles_o(cycles8)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_gcd;
    logic          exp_zero;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[$];

  function automatic int unsigned refGcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // One count per CHECK, per STRIP cycle (including the exit cycle) and per REDUCE cycle.
  function automatic int refCycles(input int unsigned x, input int unsigned y);
    int n;
    if (x == 0 || y == 0) return 1;
    n = 1;
    while (((x | y) & 1) == 0) begin
      x = x / 2;
      y = y / 2;
      n++;
    end
    n++;
    while (x != y) begin
      n++;
      if (x % 2 == 0)      x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y)      x = (x - y) / 2;
      else                 y = (y - x) / 2;
    end
    return n + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout actual=0 expected=1", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) timeoutFail("wait_in_ready");
  endtask

  // Latency counts edges from the accept edge (as edge 1) up to the edge raising out_valid.
  task automatic waitValid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    if (out_valid !== 1'b1) timeoutFail("wait_out_valid");
  endtask

  task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
    waitReady();
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    step();
    in_valid = 1'b0;
    a_in     = DW'($urandom);
    b_in     = DW'($urandom);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input int stall,
                               output logic [DW-1:0] g, output logic z, output int cyc, output int lat);
    accept(a, b);
    waitValid(lat);
    g   = gcd;
    z   = zero;
    cyc = int'(cycles);
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_gcd", gcd, g);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("release_valid", out_valid, 0);
    checkOutput("release_ready", in_ready, 1);
  endtask

  task automatic checkTxn(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] eg, input logic ez, input int ec, input int stall);
    logic [DW-1:0] g;
    logic          z;
    int            cyc, lat;
    applyStimulus(a, b, stall, g, z, cyc, lat);
    checkOutput({name, "_gcd"}, g, eg);
    checkOutput({name, "_zero"}, z, ez);
    checkOutput({name, "_cycles"}, cyc, ec);
    checkOutput({name, "_latency"}, lat, ec + 1);
  endtask

  task automatic run8(input logic [DW8-1:0] a, input logic [DW8-1:0] b,
                      input logic [DW8-1:0] eg, input logic ez, input int ec);
    int n = 0;
    while (in_ready8 !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    in_valid8 = 1'b1;
    a_in8     = a;
    b_in8     = b;
    step();
    in_valid8 = 1'b0;
    n = 0;
    while (out_valid8 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (out_valid8 !== 1'b1) timeoutFail("w8_out_valid");
    checkOutput("w8_gcd", gcd8, eg);
    checkOutput("w8_zero", zero8, ez);
    checkOutput("w8_cycles", cycles8, ec);
  endtask

  initial begin
    logic [DW-1:0] ra, rb, g;
    logic          z, seen;
    int            cyc, lat, mode;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    in_valid8 = 1'b0; a_in8 = '0; b_in8 = '0;

    vecs.push_back('{16'd12,    16'd18,    16'd6,     1'b0, 6});
    vecs.push_back('{16'd0,     16'd0,     16'd0,     1'b1, 1});
    vecs.push_back('{16'd0,     16'd7,     16'd7,     1'b0, 1});
    vecs.push_back('{16'd7,     16'd0,     16'd7,     1'b0, 1});
    vecs.push_back('{16'd7,     16'd7,     16'd7,     1'b0, 3});
    vecs.push_back('{16'd255,   16'd1,     16'd1,     1'b0, 10});
    vecs.push_back('{16'd9,     16'd6,     16'd3,     1'b0, 5});
    vecs.push_back('{16'd64,    16'd48,    16'd16,    1'b0, 10});
    vecs.push_back('{16'd32768, 16'd32768, 16'd32768, 1'b0, 18});
    vecs.push_back('{16'd65535, 16'd65534, 16'd1,     1'b0, 33});

    step();
    step();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_gcd", gcd, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_cycles", cycles, 0);
    reset = 1'b0;
    step();
    checkOutput("post_reset_in_ready", in_ready, 1);

    run8(8'd255, 8'd1, 8'd1, 1'b0, 10);
    run8(8'd0, 8'd0, 8'd0, 1'b1, 1);

    foreach (vecs[i]) begin
      checkTxn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_gcd,
               vecs[i].exp_zero, vecs[i].exp_cycles, i % 3);
    end

    $display("[TB] backpressure sequence");
    accept(16'd48, 16'd36);
    waitValid(lat);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1;
      a_in     = 16'd5;
      b_in     = 16'd10;
      step();
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_gcd", gcd, 12);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    step();
    checkOutput("bp_no_phantom", out_valid, 0);

    $display("[TB] reset during REDUCE");
    accept(16'd1000, 16'd64);
    repeat (6) step();
    checkOutput("mid_reduce_busy", in_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mid_reset_valid", out_valid, 0);
    checkOutput("mid_reset_ready", in_ready, 0);
    step();
    checkOutput("mid_after_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("mid_no_result", seen, 0);
    checkTxn("after_reset", 16'd9, 16'd6, 16'd3, 1'b0, 5, 0);

    $display("[TB] reset together with accept");
    waitReady();
    in_valid = 1'b1;
    a_in     = 16'd12;
    b_in     = 16'd18;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_acc_ready", in_ready, 0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("rst_acc_no_result", seen, 0);
    checkOutput("rst_acc_idle", in_ready, 1);

    $display("[TB] reset during DONE");
    accept(16'd7, 16'd7);
    waitValid(lat);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst_done_valid", out_valid, 0);

    $display("[TB] random regression");
    for (int i = 0; i < 1500; i++) begin
      mode = $urandom_range(0, 7);
      ra = DW'($urandom);
      rb = DW'($urandom);
      case (mode)
        0: ra = '0;
        1: rb = '0;
        2: begin
          ra = DW'($urandom_range(0, 255)) << $urandom_range(0, 8);
          rb = DW'($urandom_range(0, 255)) << $urandom_range(0, 8);
        end
        3: rb = ra;
        default: ;
      endcase
      applyStimulus(ra, rb, $urandom_range(0, 3), g, z, cyc, lat);
      checkOutput("rand_gcd", g, refGcd(ra, rb));
      checkOutput("rand_zero", z, (ra == 0) && (rb == 0));
      checkOutput("rand_cycles", cyc, refCycles(ra, rb));
      checkOutput("rand_latency", lat, refCycles(ra, rb) + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
